// File: rtl/copy_element_pkg.sv
// Shared types and sizing helpers for the copy_element_engine block.
package copy_element_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_ACK
    } state_e;

    // Upper bound on bytes per data word that the byteenable helper can describe.
    localparam int unsigned MAX_DB = 256;

    function automatic int unsigned eb_f(input int unsigned elem_w);
        return elem_w / 8;
    endfunction

    function automatic int unsigned db_f(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned lane_w_f(input int unsigned data_w, input int unsigned elem_w);
        return (data_w > elem_w) ? $clog2(data_w / elem_w) : 1;
    endfunction

    // EB contiguous byte enables starting at byte lane*EB.
    function automatic logic [MAX_DB-1:0] lane_be_f(input int unsigned lane, input int unsigned eb);
        logic [MAX_DB-1:0] ones;
        for (int unsigned i = 0; i < MAX_DB; i++) begin
            ones[i] = (i < eb);
        end
        return ones << (lane * eb);
    endfunction

endpackage

// File: rtl/copy_element_out_fifo.sv
// Synchronous result FIFO with full/empty/count status; head is visible on rdata_o.
module copy_element_out_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/copy_element_engine.sv
// Streamed single-element copy: one Avalon read, lane extract, one byte-enabled write, result FIFO.
// Optional stall counter enabled with `define COPY_ELEM_PERF_EN.
module copy_element_engine
    import copy_element_pkg::*;
#(
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned ELEM_W    = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                m_start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic                m_valid_in,
    output logic                m_ready_out,
    input  logic [31:0]         m_input_wave,
    input  logic [31:0]         m_input_fpid,
    output logic [ELEM_W-1:0]   m_output_0,
    output logic                m_valid_out,
    input  logic                m_ready_in,
    output logic [ADDR_W-1:0]   avm_ld_address,
    output logic                avm_ld_read,
    input  logic                avm_ld_waitrequest,
    input  logic [DATA_W-1:0]   avm_ld_readdata,
    input  logic                avm_ld_readdatavalid,
    output logic [4:0]          avm_ld_burstcount,
    output logic [ADDR_W-1:0]   avm_st_address,
    output logic                avm_st_write,
    input  logic                avm_st_waitrequest,
    output logic [DATA_W-1:0]   avm_st_writedata,
    output logic [DATA_W/8-1:0] avm_st_byteenable,
    input  logic                avm_st_writeack,
    output logic [4:0]          avm_st_burstcount,
    output logic                has_a_write_pending,
    output logic                has_a_lsu_active,
    output logic [31:0]         perf_stall_cycles
);

    localparam int unsigned EB     = eb_f(ELEM_W);
    localparam int unsigned DB     = db_f(DATA_W);
    localparam int unsigned LANE_W = lane_w_f(DATA_W, ELEM_W);
    localparam int unsigned LANES  = DATA_W / ELEM_W;
    localparam int unsigned LOG_EB = $clog2(EB);
    localparam int unsigned CNT_W  = $clog2(OUT_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d, st_addr_q, st_addr_d;
    logic [LANE_W-1:0]   src_lane_q, src_lane_d, dst_lane_q, dst_lane_d;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic [ADDR_W-1:0]   src_byte, dst_byte;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    assign src_byte = src_base_q + ADDR_W'(m_input_wave) * ADDR_W'(EB);
    assign dst_byte = dst_base_q + ADDR_W'(m_input_fpid) * ADDR_W'(EB);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            src_base_q <= '0;
            dst_base_q <= '0;
            ld_addr_q  <= '0;
            st_addr_q  <= '0;
            src_lane_q <= '0;
            dst_lane_q <= '0;
            elem_q     <= '0;
        end else begin
            state_q    <= state_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            ld_addr_q  <= ld_addr_d;
            st_addr_q  <= st_addr_d;
            src_lane_q <= src_lane_d;
            dst_lane_q <= dst_lane_d;
            elem_q     <= elem_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        ld_addr_d  = ld_addr_q;
        st_addr_d  = st_addr_q;
        src_lane_d = src_lane_q;
        dst_lane_d = dst_lane_q;
        elem_d     = elem_q;
        fifo_push  = 1'b0;

        if (m_start && (state_q == IDLE)) begin
            src_base_d = src_base;
            dst_base_d = dst_base;
        end

        case (state_q)
            IDLE: begin
                if (m_valid_in && m_ready_out) begin
                    ld_addr_d  = src_byte & ~ADDR_W'(DB - 1);
                    st_addr_d  = dst_byte & ~ADDR_W'(DB - 1);
                    src_lane_d = LANE_W'((src_byte & ADDR_W'(DB - 1)) >> LOG_EB);
                    dst_lane_d = LANE_W'((dst_byte & ADDR_W'(DB - 1)) >> LOG_EB);
                    state_d    = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!avm_ld_waitrequest) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm_ld_readdatavalid) begin
                    elem_d  = ELEM_W'(avm_ld_readdata >> (32'(src_lane_q) * ELEM_W));
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!avm_st_waitrequest) state_d = WR_ACK;
            end
            WR_ACK: begin
                if (avm_st_writeack) begin
                    fifo_push = !fifo_full;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_ready_out         = (state_q == IDLE) && (fifo_count < CNT_W'(OUT_DEPTH)) && !reset;
    assign avm_ld_address      = ld_addr_q;
    assign avm_ld_read         = (state_q == RD_REQ);
    assign avm_ld_burstcount   = 5'd1;
    assign avm_st_address      = st_addr_q;
    assign avm_st_write        = (state_q == WR_REQ);
    assign avm_st_writedata    = {LANES{elem_q}};
    assign avm_st_byteenable   = avm_st_write ? DB'(lane_be_f(32'(dst_lane_q), EB)) : '0;
    assign avm_st_burstcount   = 5'd1;
    assign has_a_write_pending = (state_q == WR_REQ) || (state_q == WR_ACK);
    assign has_a_lsu_active    = (state_q != IDLE);

    assign m_valid_out = !fifo_empty;
    assign fifo_pop    = m_valid_out && m_ready_in;

    copy_element_out_fifo #(
        .WIDTH (ELEM_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (elem_q),
        .pop_i   (fifo_pop),
        .rdata_o (m_output_0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef COPY_ELEM_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        stall;

    assign stall = (avm_ld_read && avm_ld_waitrequest) || (avm_st_write && avm_st_waitrequest);

    always_comb begin
        perf_d = perf_q;
        if (m_start) perf_d = '0;
        else if (stall && (perf_q != '1)) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = '0;
`endif

endmodule
